// File: rtl/rom_check_seq.sv
// Multi-region ROM integrity sequencer: streams each region's low words to
// KMAC, snoops the region's stored digest and compares it word by word.
module rom_check_seq #(
    parameter int unsigned RomDepth    = 64,
    parameter int unsigned NumRegions  = 2,
    parameter int unsigned DigestWords = 8,
    parameter bit          RecheckEn   = 1'b1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    output logic                        rom_req_o,
    output logic [((RomDepth > 1) ? $clog2(RomDepth) : 1)-1:0] rom_addr_o,
    input  logic [31:0]                 rom_data_i,
    output logic                        rom_select_o,
    output logic                        kmac_vld_o,
    output logic [31:0]                 kmac_data_o,
    output logic                        kmac_last_o,
    input  logic                        kmac_rdy_i,
    input  logic                        kmac_done_i,
    input  logic [DigestWords*32-1:0]   kmac_digest_i,
    input  logic                        kmac_err_i,
    output logic [((NumRegions > 1) ? $clog2(NumRegions) : 1)-1:0] region_idx_o,
    output logic [NumRegions-1:0]       good_o,
    output logic                        done_o,
    output logic                        alert_o
);

    localparam int unsigned AW = (RomDepth > 1) ? $clog2(RomDepth) : 1;
    localparam int unsigned RW = (NumRegions > 1) ? $clog2(NumRegions) : 1;
    localparam int unsigned IW = (DigestWords > 1) ? $clog2(DigestWords) : 1;
    localparam int unsigned RegionDepth = RomDepth / NumRegions;
    localparam int unsigned LowWords = RegionDepth - DigestWords;

    localparam logic [AW-1:0] LowNum  = AW'(LowWords);
    localparam logic [AW-1:0] LowLast = AW'(LowWords - 1);
    localparam logic [AW-1:0] HiNum   = AW'(DigestWords);
    localparam logic [IW-1:0] IdxLast = IW'(DigestWords - 1);
    localparam logic [RW-1:0] RegLast = RW'(NumRegions - 1);

    // Pairwise Hamming distance of at least 3 between all codes.
    typedef enum logic [5:0] {
        StReadLow  = 6'b000111,
        StReadHigh = 6'b011001,
        StCompare  = 6'b101010,
        StDone     = 6'b110100,
        StInvalid  = 6'b111111
    } state_e;

    state_e state_q;

    logic [RW-1:0]         region_q;
    logic [AW-1:0]         lo_cnt_q;
    logic [AW-1:0]         hi_cnt_q;
    logic                  lo_rd_q;
    logic                  held_q;
    logic                  slot_last_q;
    logic [31:0]           buf_q;
    logic                  hi_rd_q;
    logic [IW-1:0]         hi_idx_q;
    logic                  high_done_q;
    logic                  kdone_q;
    logic [IW-1:0]         cmp_idx_q;
    logic                  mism_q;
    logic [31:0]           exp_q [DigestWords];
    logic [31:0]           dig_q [DigestWords];
    logic [NumRegions-1:0] good_q;
    logic                  done_q;
    logic                  sel_q;
    logic                  alert_q;

    logic          in_low;
    logic          in_high;
    logic          accept;
    logic          lo_req;
    logic          hi_req;
    logic          mism_c;
    logic          kmac_bad;
    logic [AW-1:0] base_c;

    assign in_low  = (state_q == StReadLow);
    assign in_high = (state_q == StReadHigh);

    // The data slot is busy while a read is in flight or a word is held.
    assign kmac_vld_o  = lo_rd_q | held_q;
    assign kmac_data_o = held_q ? buf_q : rom_data_i;
    assign kmac_last_o = kmac_vld_o & slot_last_q;
    assign accept      = kmac_vld_o & kmac_rdy_i;

    assign lo_req = ~rst_i & in_low & (lo_cnt_q != LowNum) &
                    (~kmac_vld_o | kmac_rdy_i);
    assign hi_req = ~rst_i & in_high & (hi_cnt_q != HiNum);

    assign base_c     = AW'(region_q) * AW'(RegionDepth);
    assign rom_req_o  = lo_req | hi_req;
    assign rom_addr_o = base_c + (in_low ? lo_cnt_q : LowNum + hi_cnt_q);

    assign mism_c = mism_q | (exp_q[cmp_idx_q] != dig_q[cmp_idx_q]);

    assign kmac_bad = kmac_done_i &
                      (kmac_err_i | kdone_q | in_low | (state_q == StDone));

    assign rom_select_o = sel_q;
    assign region_idx_o = region_q;
    assign good_o       = good_q;
    assign done_o       = done_q;
    assign alert_o      = alert_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StReadLow;
            region_q    <= '0;
            lo_cnt_q    <= '0;
            hi_cnt_q    <= '0;
            lo_rd_q     <= 1'b0;
            held_q      <= 1'b0;
            slot_last_q <= 1'b0;
            buf_q       <= '0;
            hi_rd_q     <= 1'b0;
            hi_idx_q    <= '0;
            high_done_q <= 1'b0;
            kdone_q     <= 1'b0;
            cmp_idx_q   <= '0;
            mism_q      <= 1'b0;
            good_q      <= '0;
            done_q      <= 1'b0;
            sel_q       <= 1'b1;
            alert_q     <= 1'b0;
        end else begin
            lo_rd_q  <= lo_req;
            hi_rd_q  <= hi_req;
            hi_idx_q <= IW'(hi_cnt_q);
            held_q   <= kmac_vld_o & ~kmac_rdy_i;
            if (kmac_vld_o & ~kmac_rdy_i) begin
                buf_q <= kmac_data_o;
            end
            if (lo_req) begin
                slot_last_q <= (lo_cnt_q == LowLast);
                lo_cnt_q    <= lo_cnt_q + 1'b1;
            end else if (accept) begin
                slot_last_q <= 1'b0;
            end
            if (hi_req) begin
                hi_cnt_q <= hi_cnt_q + 1'b1;
            end
            if (hi_rd_q) begin
                exp_q[hi_idx_q] <= rom_data_i;
                if (hi_idx_q == IdxLast) begin
                    high_done_q <= 1'b1;
                end
            end
            if (kmac_done_i) begin
                kdone_q <= 1'b1;
                for (int i = 0; i < DigestWords; i++) begin
                    dig_q[i] <= kmac_digest_i[32*i +: 32];
                end
            end

            case (state_q)
                StReadLow: begin
                    if (accept & slot_last_q) begin
                        state_q <= StReadHigh;
                    end
                end
                StReadHigh: begin
                    if (high_done_q & kdone_q) begin
                        state_q   <= StCompare;
                        cmp_idx_q <= '0;
                        mism_q    <= 1'b0;
                    end
                end
                StCompare: begin
                    mism_q    <= mism_c;
                    cmp_idx_q <= cmp_idx_q + 1'b1;
                    if (cmp_idx_q == IdxLast) begin
                        good_q[region_q] <= ~mism_c;
                        if (region_q == RegLast) begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                            sel_q   <= 1'b0;
                        end else begin
                            state_q     <= StReadLow;
                            region_q    <= region_q + 1'b1;
                            kdone_q     <= 1'b0;
                            high_done_q <= 1'b0;
                            lo_cnt_q    <= '0;
                            hi_cnt_q    <= '0;
                            cmp_idx_q   <= '0;
                            mism_q      <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    if (start_i && RecheckEn) begin
                        state_q     <= StReadLow;
                        region_q    <= '0;
                        good_q      <= '0;
                        done_q      <= 1'b0;
                        sel_q       <= 1'b1;
                        kdone_q     <= 1'b0;
                        high_done_q <= 1'b0;
                        lo_cnt_q    <= '0;
                        hi_cnt_q    <= '0;
                        cmp_idx_q   <= '0;
                        mism_q      <= 1'b0;
                    end
                end
                StInvalid: begin
                end
                default: begin
                    state_q <= StInvalid;
                    alert_q <= 1'b1;
                end
            endcase

            if (kmac_bad) begin
                state_q <= StInvalid;
                alert_q <= 1'b1;
                done_q  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rom_check_seq.sv
// Scoreboard bench for rom_check_seq: two-region ROM, KMAC model driven
// from the golden image, recheck enabled on u_dut and disabled on u_dut_nr.
module tb_rom_check_seq;

    logic         clk;
    logic         rst;
    logic         start;
    logic         kmac_rdy;
    logic         kmac_done;
    logic         kmac_err;
    logic [127:0] kmac_dig;

    logic        req0, req1;
    logic [4:0]  addr0, addr1;
    logic [31:0] rdata0, rdata1;
    logic        sel0, sel1;
    logic        vld0, vld1;
    logic [31:0] kdata0, kdata1;
    logic        last0, last1;
    logic [0:0]  ridx0, ridx1;
    logic [1:0]  good0, good1;
    logic        done0, done1;
    logic        alert0, alert1;

    logic [31:0] rom  [32];
    logic [31:0] gold [32];
    logic [32:0] sbq [$];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_beats = 0;
    int  n_last  = 0;
    bit  sb_en   = 1'b0;
    bit  rdy_mode = 1'b0;

    rom_check_seq #(
        .RomDepth(32), .NumRegions(2), .DigestWords(4), .RecheckEn(1'b1)
    ) u_dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .rom_req_o(req0), .rom_addr_o(addr0), .rom_data_i(rdata0),
        .rom_select_o(sel0), .kmac_vld_o(vld0), .kmac_data_o(kdata0),
        .kmac_last_o(last0), .kmac_rdy_i(kmac_rdy), .kmac_done_i(kmac_done),
        .kmac_digest_i(kmac_dig), .kmac_err_i(kmac_err),
        .region_idx_o(ridx0), .good_o(good0), .done_o(done0),
        .alert_o(alert0)
    );

    rom_check_seq #(
        .RomDepth(32), .NumRegions(2), .DigestWords(4), .RecheckEn(1'b0)
    ) u_dut_nr (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .rom_req_o(req1), .rom_addr_o(addr1), .rom_data_i(rdata1),
        .rom_select_o(sel1), .kmac_vld_o(vld1), .kmac_data_o(kdata1),
        .kmac_last_o(last1), .kmac_rdy_i(kmac_rdy), .kmac_done_i(kmac_done),
        .kmac_digest_i(kmac_dig), .kmac_err_i(kmac_err),
        .region_idx_o(ridx1), .good_o(good1), .done_o(done1),
        .alert_o(alert1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ROM: data valid exactly one cycle after a request, junk otherwise.
    always @(posedge clk) begin
        rdata0 <= req0 ? rom[addr0] : $urandom();
        rdata1 <= req1 ? rom[addr1] : $urandom();
    end

    initial begin
        logic [3:0] pat;
        int ph;
        pat = 4'b1001;
        ph = 0;
        kmac_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_mode) begin
                kmac_rdy = pat[ph];
                ph = (ph + 1) % 4;
            end else begin
                kmac_rdy = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // KMAC stream monitor: beat scoreboard and hold-stability checks.
    initial begin
        bit hold_pend;
        logic [31:0] hd;
        logic hl;
        logic [32:0] e;
        hold_pend = 1'b0;
        hd = '0;
        hl = 1'b0;
        forever begin
            @(negedge clk);
            if (hold_pend && sb_en && !rst) begin
                chk("hold_vld", 64'(vld0), 64'd1);
                chk("hold_data", 64'(kdata0), 64'(hd));
                chk("hold_last", 64'(last0), 64'(hl));
            end
            hold_pend = 1'b0;
            if (!rst && vld0) begin
                if (!kmac_rdy) begin
                    hold_pend = 1'b1;
                    hd = kdata0;
                    hl = last0;
                end else begin
                    n_beats++;
                    if (last0) n_last++;
                    if (sb_en) begin
                        if (sbq.size() == 0) begin
                            chk("sb_underflow", 64'(kdata0), 64'h1_0000_0000);
                        end else begin
                            e = sbq.pop_front();
                            chk("kmac_beat", 64'({last0, kdata0}), 64'(e));
                        end
                    end
                end
            end
        end
    end

    function automatic logic [127:0] dig_of(input int r);
        logic [127:0] d;
        for (int i = 0; i < 4; i++) d[32*i +: 32] = gold[r*16 + 12 + i];
        return d;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        kmac_done = 1'b0;
        kmac_err = 1'b0;
        kmac_dig = '0;
        sbq.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 64'(req0), 64'd0);
        chk("rst_vld", 64'(vld0), 64'd0);
        chk("rst_last", 64'(last0), 64'd0);
        chk("rst_sel", 64'(sel0), 64'd1);
        chk("rst_good", 64'(good0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_alert", 64'(alert0), 64'd0);
        chk("rst_region", 64'(ridx0), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("first_req", 64'(req0), 64'd1);
        chk("first_addr", 64'(addr0), 64'd0);
    endtask

    task automatic pulse_done(input int r, input bit err);
        kmac_dig = dig_of(r);
        kmac_err = err;
        kmac_done = 1'b1;
        @(posedge clk);
        #1;
        kmac_done = 1'b0;
        kmac_err = 1'b0;
    endtask

    task automatic wait_last(input int target);
        int k;
        k = 0;
        while (n_last < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        chk("last_wait", 64'(n_last >= target), 64'd1);
    endtask

    // early[r]=1: KMAC finishes before the region's high reads complete.
    task automatic run_seq(input logic [1:0] early, input logic [1:0] exp_good);
        int b0;
        int l0;
        int k;
        b0 = n_beats;
        l0 = n_last;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 12; i++)
                sbq.push_back({i == 11, rom[r*16 + i]});
        for (int r = 0; r < 2; r++) begin
            wait_last(l0 + r + 1);
            @(posedge clk);
            if (!early[r]) repeat (10) @(posedge clk);
            #1;
            pulse_done(r, 1'b0);
        end
        k = 0;
        while (!done0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("done", 64'(done0), 64'd1);
        chk("good", 64'(good0), 64'(exp_good));
        chk("sel_released", 64'(sel0), 64'd0);
        chk("no_alert", 64'(alert0), 64'd0);
        chk("sb_drain", 64'(sbq.size()), 64'd0);
        chk("beats", 64'(n_beats - b0), 64'd24);
    endtask

    task automatic alert_seq(input string tag);
        @(negedge clk);
        chk({tag, "_pre"}, 64'(alert0), 64'd0);
        @(posedge clk);
        #1;
        kmac_done = 1'b0;
        kmac_err = 1'b0;
        @(negedge clk);
        chk({tag, "_rise"}, 64'(alert0), 64'd1);
        repeat (20) @(negedge clk);
        chk({tag, "_hold"}, 64'(alert0), 64'd1);
        chk({tag, "_nodone"}, 64'(done0), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            rom[i] = $urandom();
            gold[i] = rom[i];
        end

        // Matching ROM, KMAC early in region 0 and late in region 1.
        sb_en = 1'b1;
        do_reset();
        run_seq(2'b01, 2'b11);
        chk("nr_good", 64'(good1), 64'd3);
        chk("nr_done", 64'(done1), 64'd1);

        // Recheck from Done: only the RecheckEn instance restarts.
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("rchk_good", 64'(good0), 64'd0);
        chk("rchk_sel", 64'(sel0), 64'd1);
        chk("rchk_done", 64'(done0), 64'd0);
        chk("rchk_req", 64'(req0), 64'd1);
        chk("rchk_addr", 64'(addr0), 64'd0);
        chk("nr_good_kept", 64'(good1), 64'd3);
        chk("nr_done_kept", 64'(done1), 64'd1);
        chk("nr_sel_kept", 64'(sel1), 64'd0);
        run_seq(2'b10, 2'b11);

        // Corrupted region 1 digest word 2, with a stalling KMAC.
        rom[30] = rom[30] ^ 32'h0000_0100;
        rdy_mode = 1'b1;
        do_reset();
        run_seq(2'b01, 2'b01);
        rom[30] = gold[30];
        rdy_mode = 1'b0;

        // KMAC done while still streaming low words.
        sb_en = 1'b0;
        do_reset();
        repeat (3) @(posedge clk);
        #1 kmac_done = 1'b1;
        alert_seq("alert_low");

        // KMAC done with error during the high reads.
        do_reset();
        wait_last(n_last + 1);
        @(posedge clk);
        #1;
        kmac_dig = dig_of(0);
        kmac_err = 1'b1;
        kmac_done = 1'b1;
        alert_seq("alert_err");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rom_check_seq.md
# rom_check_seq

Parametrised ROM integrity checker sequencer, successor to the single-region ROM checker FSM. It splits the ROM into `NumRegions` equal regions and processes each region in turn. For each region it streams the low words to KMAC, snoops the top `DigestWords` words as that region's expected digest, and compares the two word by word. It owns the ROM mux until all regions are checked, reports a per-region pass vector, and supports a software-triggered re-check.

## Interface
- `RomDepth`, 64: ROM depth in 32-bit words; must be a multiple of `NumRegions`.
- `NumRegions`, 2: number of independently hashed regions, 1..8.
- `DigestWords`, 8: digest length in 32-bit words; `RegionDepth = RomDepth/NumRegions` must exceed `DigestWords`.
- `RecheckEn`, 1: 1 means `start_i` in Done re-runs the full sequence; 0 means `start_i` is ignored.

Ports:
- `clk_i`  in  1  single clock.
- `rst_i`  in  1  synchronous, active-high reset.
- `start_i`  in  1  re-check request pulse.
- `rom_req_o`  out  1  ROM read strobe.
- `rom_addr_o`  out  vbits(RomDepth)  ROM word address.
- `rom_data_i`  in  32  ROM data, valid exactly 1 cycle after `rom_req_o`.
- `rom_select_o`  out  1  1 while this block owns the ROM mux.
- `kmac_vld_o`  out  1  KMAC data valid.
- `kmac_data_o`  out  32  KMAC data.
- `kmac_last_o`  out  1  marks the last low word of the current region.
- `kmac_rdy_i`  in  1  KMAC ready.
- `kmac_done_i`  in  1  digest-valid pulse.
- `kmac_digest_i`  in  DigestWords*32  digest, word 0 in the LSBs.
- `kmac_err_i`  in  1  KMAC error, sampled with `kmac_done_i`.
- `region_idx_o`  out  vbits(NumRegions)  region currently being processed.
- `good_o`  out  NumRegions  per-region pass flags.
- `done_o`  out  1  all regions checked.
- `alert_o`  out  1  fatal alert.

## Operation
- States: ReadLow, ReadHigh, Compare, Done, Invalid. Encoding is sparse with pairwise Hamming distance ≥3. Any unlisted encoding goes to Invalid.
- Address within a region: `base = region*RegionDepth`. Low words are `base .. base+RegionDepth-DigestWords-1`. High words are the next `DigestWords`.
- ReadLow:
  - A single-entry data buffer feeds KMAC.
  - A read is issued when the buffer is empty, or when it is being consumed that cycle (`kmac_vld_o & kmac_rdy_i`).
  - `kmac_vld_o` stays high until accepted, with data and `kmac_last_o` held stable.
  - After the last low word is accepted, the FSM enters ReadHigh.
- ReadHigh:
  - Issue one read per cycle for the high words.
  - Capture each returned word into `exp_q[i]`.
  - `high_done` is set when the last word has been captured.
- KMAC completion: `kmac_done_i` is legal only in ReadHigh and Compare-wait. When it arrives, latch `kmac_digest_i` into `dig_q` and set `kdone_q`.
- Race between high reads and KMAC: the order of `high_done` and `kdone_q` is irrelevant. Compare starts in the cycle after both are set.
- Compare:
  - One word per cycle, index 0 to `DigestWords-1`.
  - A mismatch flag accumulates across the words.
  - At the last word, `good_o[region]` is set to `~mismatch`.
  - If the region was the last one, go to Done. Otherwise increment the region, clear `kdone_q`, `high_done` and the counters, and return to ReadLow.
- Done:
  - `done_o=1` and `rom_select_o=0`.
  - A `start_i` pulse with `RecheckEn=1` clears `good_o`, sets region to 0 and enters ReadLow.
- Invalid: terminal until reset, `alert_o=1`. Entered on any of:
  - `kmac_err_i` together with `kmac_done_i`;
  - `kmac_done_i` in ReadLow or Done;
  - a second `kmac_done_i` while `kdone_q` is already set;
  - an illegal state encoding.
- A digest mismatch does not raise an alert.

## Timing
- Reset values: state ReadLow, region 0, `rom_select_o=1`, `rom_req_o=0`, `kmac_vld_o=0`, `kmac_last_o=0`, `good_o=0`, `done_o=0`, `alert_o=0`.
- First `rom_req_o` is issued in the first cycle after `rst_i` deasserts.
- With `kmac_rdy_i` held at 1, the low-word stream runs at 1 word per cycle, and the first `kmac_vld_o` appears 1 cycle after the first `rom_req_o`.
- ReadHigh takes `DigestWords` read cycles plus 1 cycle for the final capture.
- Compare takes `DigestWords` cycles. `good_o` and the state update on the clock edge ending the last compare cycle.
- `alert_o` rises one cycle after the triggering event and stays high.
- `start_i` has no effect outside Done, and `rst_i` aborts operation at any point, including mid-stream. Either way, no partial results are kept.

## Test plan
Bench configuration: `RomDepth=32`, `NumRegions=2`, `DigestWords=4`, so each region has 12 low words and 4 high words.

- Matching ROM, `kmac_rdy_i=1`, KMAC returns the correct digests → 12 `kmac_vld_o` beats per region with `kmac_last_o` on the 12th, `good_o=2'b11`, `done_o=1`, `rom_select_o=0`.
- Region 1 top word 2 corrupted → `good_o=2'b01`, `alert_o=0`.
- `kmac_done_i` arrives before the high reads finish, in one region, and after them in the other → both regions compare correctly with identical results.
- `kmac_rdy_i` toggling 1,0,0,1 → data and `kmac_last_o` held stable while `kmac_vld_o=1`; no word dropped or duplicated (scoreboard against addresses 0..11 and 16..27).
- `kmac_done_i` with `kmac_err_i=1`, or `kmac_done_i` in ReadLow → `alert_o=1` the next cycle and permanently; `done_o` stays 0.
- In Done, pulse `start_i` → `good_o` cleared to 0, `rom_select_o=1`, reads restart at address 0. Repeat with `RecheckEn=0` → no change.
